width_conv_fifo: RTL and testbench

Parametrised, single-clock, width-converting FIFO for the packet buffer: accepts wide words on the write side and delivers them as narrow segments, least-significant segment first. It is portable RTL on inferred block RAM rather than a hard FIFO primitive. It adds configurable depth and width ratio, partial last words, selectable first-word-fall-through or standard read mode, and level, almost-full and error reporting. It sits between the capture datapath (wide) and the byte-oriented packet parser.

---
 rtl/width_conv_fifo.sv | 117 +++++++++++
 tb/tb_width_conv_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/width_conv_fifo.sv
// Width-converting FIFO: wide words in, narrow segments out (least-significant first),
// with partial last words, FWFT or standard read mode, and level/flag reporting.
module width_conv_fifo #(
  parameter int WRITE_WIDTH        = 64,
  parameter int READ_WIDTH         = 8,
  parameter int DEPTH              = 512,
  parameter bit FWFT               = 1'b1,
  parameter int ALMOST_FULL_THRESH = DEPTH - 4,
  localparam int RATIO = WRITE_WIDTH / READ_WIDTH,
  localparam int SW    = $clog2(RATIO) + 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_en_i,
  input  logic [WRITE_WIDTH-1:0] data_i,
  input  logic [SW-1:0]          valid_segs_i,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   overflow_o,
  input  logic                   read_en_i,
  output logic [READ_WIDTH-1:0]  data_o,
  output logic                   word_last_o,
  output logic                   empty_o,
  output logic                   underflow_o,
  output logic [LW-1:0]          level_o
);

  localparam int AW = LW - 1;
  localparam int IW = SW - 1;

  typedef struct packed {
    logic [SW-1:0]          segs;
    logic [WRITE_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        fe_entry;
  logic [LW-1:0] wr_ptr, rd_ptr, fe_ptr, level_nxt;
  logic [IW-1:0] seg_q, seg_nxt;
  logic [SW-1:0] segs_norm, head_last;
  logic          wr_acc, pop, pop_last, load;

  always_comb begin
    // NOTE: default assignment first so every path drives segs_norm and no latch is inferred.
    segs_norm = valid_segs_i;
    if (valid_segs_i == '0 || valid_segs_i > SW'(RATIO)) segs_norm = SW'(RATIO);
  end

  // fe_ptr runs one word ahead of rd_ptr while a head word is held, so the
  // next word can be fetched on the same edge that finishes the current one.
  assign fe_entry  = mem[fe_ptr[AW-1:0]];
  assign head_last = head_q.segs - SW'(1);
  assign seg_nxt   = seg_q + IW'(1);
  assign wr_acc    = write_en_i & ~full_o & ~rst_i;
  assign pop       = read_en_i & ~empty_o & ~rst_i;
  assign pop_last  = pop & ({1'b0, seg_q} == head_last);
  assign load      = (empty_o | pop_last) & (fe_ptr != wr_ptr) & ~rst_i;
  assign level_nxt = (wr_ptr + LW'(wr_acc)) - (rd_ptr + LW'(pop_last));

  // NOTE: storage and the head word carry no reset; empty_o and the pointers
  // decide what is valid, which keeps the array mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= '{segs: segs_norm, data: data_i};
    if (load)   head_q <= fe_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fe_ptr        <= '0;
      seg_q         <= '0;
      empty_o       <= 1'b1;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      level_o       <= '0;
      data_o        <= '0;
      word_last_o   <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      overflow_o    <= write_en_i & full_o;
      underflow_o   <= read_en_i & empty_o;
      level_o       <= level_nxt;
      full_o        <= (level_nxt == LW'(DEPTH));
      almost_full_o <= (level_nxt >= LW'(ALMOST_FULL_THRESH));

      if (wr_acc)   wr_ptr <= wr_ptr + LW'(1);
      if (pop_last) rd_ptr <= rd_ptr + LW'(1);
      if (pop)      seg_q  <= pop_last ? '0 : seg_nxt;

      if (load) begin
        fe_ptr  <= fe_ptr + LW'(1);
        empty_o <= 1'b0;
      end else if (pop_last) begin
        empty_o <= 1'b1;
      end

      if (FWFT) begin
        // Present the segment that will be at the head after this edge.
        if (load) begin
          data_o      <= fe_entry.data[READ_WIDTH-1:0];
          word_last_o <= (fe_entry.segs == SW'(1));
        end else if (pop && !pop_last) begin
          data_o      <= head_q.data[READ_WIDTH*seg_nxt +: READ_WIDTH];
          word_last_o <= ({1'b0, seg_nxt} == head_last);
        end
      end else if (pop) begin
        data_o      <= head_q.data[READ_WIDTH*seg_q +: READ_WIDTH];
        word_last_o <= pop_last;
      end
    end
  end

endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo: directed steps on an FWFT and a standard-mode instance,
// plus a randomized stream scored against a word-queue reference model.
module tb_width_conv_fifo;

  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        write_en, read_en, full, afull, ovf, last, empty, unf;
  logic [63:0] data_in;
  logic [3:0]  segs_in;
  logic [7:0]  dout;
  logic [4:0]  level;

  logic        write_en_b, read_en_b, full_b, afull_b, ovf_b, last_b, empty_b, unf_b;
  logic [63:0] data_in_b;
  logic [3:0]  segs_in_b;
  logic [7:0]  dout_b;
  logic [4:0]  level_b;

  width_conv_fifo #(.WRITE_WIDTH(64), .READ_WIDTH(8), .DEPTH(DEPTH), .FWFT(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write_en_i(write_en), .data_i(data_in),
    .valid_segs_i(segs_in), .full_o(full), .almost_full_o(afull), .overflow_o(ovf),
    .read_en_i(read_en), .data_o(dout), .word_last_o(last), .empty_o(empty),
    .underflow_o(unf), .level_o(level));

  width_conv_fifo #(.WRITE_WIDTH(64), .READ_WIDTH(8), .DEPTH(DEPTH), .FWFT(1'b0)) dut_std (
    .clk_i(clk_i), .rst_i(rst_i), .write_en_i(write_en_b), .data_i(data_in_b),
    .valid_segs_i(segs_in_b), .full_o(full_b), .almost_full_o(afull_b), .overflow_o(ovf_b),
    .read_en_i(read_en_b), .data_o(dout_b), .word_last_o(last_b), .empty_o(empty_b),
    .underflow_o(unf_b), .level_o(level_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [63:0] data;
    int          n;
  } word_t;

  word_t wq[$];

  function automatic int norm_segs(input logic [3:0] v);
    return (v == 0 || v > 8) ? 8 : int'(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] part_exp [4];
    logic       part_last [4];
    int         seg_idx, accepted, cyc, old_level, n;
    logic       do_wr, do_rd, pop_ok, old_empty;
    logic [63:0] w;
    word_t      nw;

    rst_i = 1'b1;
    write_en = 0; read_en = 0; data_in = '0; segs_in = '0;
    write_en_b = 0; read_en_b = 0; data_in_b = '0; segs_in_b = '0;
    tick; tick;
    check("rst_empty", empty, 1);       check("rst_full", full, 0);
    check("rst_afull", afull, 0);       check("rst_level", level, 0);
    check("rst_data", dout, 0);         check("rst_last", last, 0);
    check("rst_ovf", ovf, 0);           check("rst_unf", unf, 0);
    check("rst_std_empty", empty_b, 1); check("rst_std_data", dout_b, 0);
    rst_i = 1'b0;

    // Pop while empty
    read_en = 1; tick; read_en = 0;
    check("unf_pulse", unf, 1); check("unf_data", dout, 0); check("unf_level", level, 0);
    tick;
    check("unf_clear", unf, 0);

    // Full word, FWFT
    write_en = 1; data_in = 64'h0807060504030201; segs_in = 4'd8; tick; write_en = 0;
    check("w1_level", level, 1); check("w1_empty_latency", empty, 1);
    tick;
    check("w1_ready", empty, 0);
    for (int i = 1; i <= 8; i++) begin
      check("fwft_data", dout, i); check("fwft_last", last, (i == 8));
      read_en = 1; tick;
    end
    read_en = 0;
    check("w1_drained_empty", empty, 1); check("w1_drained_level", level, 0);

    // Partial words
    part_exp  = '{8'h0A, 8'h0B, 8'h0C, 8'h11};
    part_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    write_en = 1; data_in = 64'hFFFF_FFFF_FF0C_0B0A; segs_in = 4'd3; tick;
    data_in = 64'hFFFF_FFFF_FFFF_FF11; segs_in = 4'd1; tick; write_en = 0;
    check("part_level", level, 2);
    for (int i = 0; i < 4; i++) begin
      check("part_avail", empty, 0); check("part_data", dout, part_exp[i]);
      check("part_last", last, part_last[i]);
      read_en = 1; tick;
    end
    read_en = 0;
    check("part_empty", empty, 1); check("part_level0", level, 0);

    // Reset mid-operation, with a write presented during reset
    write_en = 1; segs_in = 4'd8;
    for (int i = 0; i < 3; i++) begin data_in = {8{8'h30 + 8'(i)}}; tick; end
    check("pre_rst_level", level, 3);
    rst_i = 1; tick; rst_i = 0; write_en = 0;
    check("midrst_level", level, 0); check("midrst_empty", empty, 1);
    check("midrst_data", dout, 0);
    tick; tick;
    check("midrst_ignored_write", empty, 1); check("midrst_level_hold", level, 0);

    // Fill to capacity
    write_en = 1; segs_in = 4'd1;
    for (int k = 0; k < DEPTH; k++) begin
      data_in = {56'hFFFF_FFFF_FFFF_FF, 8'h20 + 8'(k)}; tick;
      check("fill_level", level, k + 1);
      check("fill_afull", afull, (k + 1 >= 12));
      check("fill_full", full, (k + 1 == DEPTH));
    end
    data_in = 64'hEE; tick; write_en = 0;
    check("ovf_pulse", ovf, 1); check("ovf_level", level, DEPTH); check("ovf_full", full, 1);
    tick;
    check("ovf_clear", ovf, 0);
    check("full_head", dout, 8'h20);
    write_en = 1; data_in = 64'hEF; read_en = 1; tick; write_en = 0; read_en = 0;
    check("ovf_rw_pulse", ovf, 1); check("ovf_rw_level", level, DEPTH - 1);
    check("ovf_rw_full", full, 0);
    for (int k = 1; k < DEPTH; k++) begin
      check("drain_avail", empty, 0); check("drain_data", dout, 8'h20 + 8'(k));
      check("drain_last", last, 1);
      read_en = 1; tick;
    end
    read_en = 0;
    check("drain_empty", empty, 1); check("drain_level", level, 0);

    // Randomized stream against reference model
    seg_idx = 0; accepted = 0; cyc = 0;
    while ((accepted < 100 || wq.size() != 0) && cyc < 4000) begin
      do_wr = (accepted < 100) && ($urandom_range(0, 9) < 6);
      do_rd = $urandom_range(0, 9) < ((accepted < 50) ? 3 : 8);
      write_en = do_wr; data_in = {$urandom, $urandom}; segs_in = 4'($urandom_range(0, 15));
      read_en = do_rd;
      pop_ok = do_rd && !empty;
      if (!empty) check("rand_nonempty", (wq.size() != 0), 1);
      if (pop_ok && wq.size() != 0) begin
        w = wq[0].data >> (8 * seg_idx);
        check("rand_data", dout, w[7:0]);
        check("rand_last", last, (seg_idx == wq[0].n - 1));
      end
      old_level = wq.size(); old_empty = empty;
      tick; cyc++;
      if (pop_ok && wq.size() != 0) begin
        if (seg_idx == wq[0].n - 1) begin
          void'(wq.pop_front());
          seg_idx = 0;
        end else begin
          seg_idx++;
        end
      end
      if (do_wr && old_level < DEPTH) begin
        nw.data = data_in; nw.n = norm_segs(segs_in);
        wq.push_back(nw);
        accepted++;
      end
      check("rand_level", level, wq.size());
      check("rand_level_bound", (level <= DEPTH), 1);
      check("rand_full", full, (wq.size() == DEPTH));
      check("rand_afull", afull, (wq.size() >= 12));
      check("rand_ovf", ovf, (do_wr && old_level == DEPTH));
      check("rand_unf", unf, (do_rd && old_empty));
    end
    write_en = 0; read_en = 0;
    check("rand_completed", (cyc < 4000), 1);
    check("rand_end_empty", empty, 1);

    // Standard read mode
    write_en_b = 1; data_in_b = 64'h0807060504030201; segs_in_b = 4'd8; tick; write_en_b = 0;
    n = 0;
    while (empty_b && n < 10) begin tick; n++; end
    check("std_ready", empty_b, 0);
    check("std_no_pop_data", dout_b, 0);
    read_en_b = 1; tick; read_en_b = 0;
    check("std_first", dout_b, 8'h01); check("std_first_last", last_b, 0);
    tick; tick;
    check("std_hold", dout_b, 8'h01);
    for (int i = 2; i <= 8; i++) begin
      read_en_b = 1; tick;
      check("std_data", dout_b, i); check("std_last", last_b, (i == 8));
    end
    read_en_b = 0;
    check("std_empty", empty_b, 1); check("std_level", level_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
